calc_sequencer: RTL and testbench

Multi-cycle sequencer for the calculator datapath. It sequences operand entry into the 2-entry register file, issues one ALU operation per pass using a start/done handshake so multi-cycle operations such as multiply are supported, writes the result back into RF[0] for chained calculations, and reports errors for invalid modes and ALU timeouts. It replaces single-cycle "next"-driven state stepping with a fully synchronous controller that sits between the push-button/switch inputs and the register file and ALU.

---
 rtl/calc_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// -----------------------------------------------------------------------------
// calc_sequencer
//
// Multi-cycle controller for the calculator datapath. It steps operand entry
// into the 2-entry register file from a push button, launches one ALU
// operation per pass with a start/done handshake (so multi-cycle operations
// such as multiply fit), writes the result back into RF[0] so that the next
// operation can chain on it, and flags invalid modes and ALU timeouts.
//
// Parameters
//   TIMEOUT    maximum number of cycles spent in WAIT for alu_done (>= 2)
//
// Ports
//   CLK        in   system clock, all state changes on the rising edge
//   clear      in   synchronous active-high reset
//   next       in   raw step button (asynchronous level)
//   MS[2:0]    in   mode select: 001 add, 010 sub, 011 mul, 100 xor
//   alu_done   in   one-cycle pulse from the ALU, result valid
//   CS_out     out  current state encoding (LEDs)
//   WE         out  register file write enable (operand load)
//   W1         out  register file write address (0 -> RF[0], 1 -> RF[1])
//   RES_WE     out  write ALU result into RF[0]
//   MS_out     out  mode sent to the ALU
//   alu_start  out  one-cycle ALU launch pulse
//   Done_out   out  result valid for display
//   err        out  error indicator
// -----------------------------------------------------------------------------
module calc_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic       CLK,
  input  logic       clear,
  input  logic       next,
  input  logic [2:0] MS,
  input  logic       alu_done,
  output logic [2:0] CS_out,
  output logic       WE,
  output logic       W1,
  output logic       RES_WE,
  output logic [2:0] MS_out,
  output logic       alu_start,
  output logic       Done_out,
  output logic       err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // State codes are visible on the LEDs, so the encoding is fixed.
  typedef enum logic [2:0] {
    IDLE1 = 3'b000,
    LOAD1 = 3'b001,
    IDLE2 = 3'b010,
    LOAD2 = 3'b011,
    ISSUE = 3'b100,
    WAIT  = 3'b101,
    DONE  = 3'b110,
    ERR   = 3'b111
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic             s0;
  logic             s1;
  logic             prev;
  logic             next_rise;

  logic [2:0]       ms_q;
  logic             ms_valid;

  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  // ---------------------------------------------------------------------------
  // Button synchronizer and rising-edge detector. s0/s1 tame metastability on
  // the asynchronous level; prev holds the previous synchronized sample so a
  // held button produces exactly one next_rise.
  // ---------------------------------------------------------------------------
  // NOTE: every flop is written with <= so all registers update from the same
  // pre-edge values; blocking assignments here would collapse s0->s1->prev.
  always_ff @(posedge CLK) begin
    if (clear) begin
      s0   <= 1'b0;
      s1   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s0   <= next;
      s1   <= s0;
      prev <= s1;
    end
  end

  assign next_rise = s1 & ~prev;

  // ---------------------------------------------------------------------------
  // Mode register: sampled on the edge leaving LOAD2, so the ALU sees a stable
  // mode for the whole ISSUE/WAIT/DONE pass even if the switches move.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (clear) begin
      ms_q <= 3'b000;
    end else if (state_q == LOAD2) begin
      ms_q <= MS;
    end
  end

  assign ms_valid = (ms_q >= 3'b001) && (ms_q <= 3'b100);

  // ---------------------------------------------------------------------------
  // WAIT cycle counter. It reads 0 in the first WAIT cycle and n-1 in the n-th,
  // so reaching TIMEOUT-1 without alu_done means the TIMEOUT-th cycle is
  // ending unanswered.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (clear) begin
      wait_cnt <= '0;
    end else if (state_q == ISSUE) begin
      wait_cnt <= '0;
    end else if (state_q == WAIT) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (clear) begin
      state_q <= IDLE1;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Button edges outside the waiting states are dropped
  // simply by not being looked at.
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE1: if (next_rise) state_d = LOAD1;
      LOAD1: state_d = IDLE2;
      IDLE2: if (next_rise) state_d = LOAD2;
      LOAD2: state_d = ISSUE;
      ISSUE: state_d = ms_valid ? WAIT : ERR;
      WAIT: begin
        // alu_done in the last allowed cycle still wins over the timeout.
        if (alu_done) begin
          state_d = DONE;
        end else if (timeout_hit) begin
          state_d = ERR;
        end
      end
      DONE:  if (next_rise) state_d = LOAD2;   // chain on the result in RF[0]
      ERR:   if (next_rise) state_d = IDLE1;
      default: state_d = IDLE1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs: Moore-decoded from the state register, except RES_WE which must
  // fire in the same cycle as alu_done to catch the ALU result.
  // ---------------------------------------------------------------------------
  always_comb begin
    CS_out    = state_q;
    WE        = 1'b0;
    W1        = 1'b0;
    RES_WE    = 1'b0;
    MS_out    = 3'b000;
    alu_start = 1'b0;
    Done_out  = 1'b0;
    err       = 1'b0;
    case (state_q)
      LOAD1: WE = 1'b1;
      IDLE2: W1 = 1'b1;
      LOAD2: begin
        WE = 1'b1;
        W1 = 1'b1;
      end
      ISSUE: begin
        W1        = 1'b1;
        MS_out    = ms_q;
        alu_start = ms_valid;
      end
      WAIT: begin
        W1     = 1'b1;
        MS_out = ms_q;
        RES_WE = alu_done;
      end
      DONE: begin
        W1       = 1'b1;
        MS_out   = ms_q;
        Done_out = 1'b1;
      end
      ERR:     err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_calc_sequencer
//
// Self-checking bench for calc_sequencer. A transaction-level reference model
// decides, from the mode, the ALU latency and the injected events, which
// named phase the sequencer should be in each cycle; the expected output word
// for a phase comes from the per-state output table.
// -----------------------------------------------------------------------------
module tb_calc_sequencer;

  localparam int TIMEOUT = 16;

  typedef enum logic [2:0] {
    P_IDLE1 = 3'b000,
    P_LOAD1 = 3'b001,
    P_IDLE2 = 3'b010,
    P_LOAD2 = 3'b011,
    P_ISSUE = 3'b100,
    P_WAIT  = 3'b101,
    P_DONE  = 3'b110,
    P_ERR   = 3'b111
  } ph_t;

  logic       CLK = 1'b0;
  logic       clear;
  logic       next;
  logic [2:0] MS;
  logic       alu_done;
  logic [2:0] CS_out;
  logic       WE;
  logic       W1;
  logic       RES_WE;
  logic [2:0] MS_out;
  logic       alu_start;
  logic       Done_out;
  logic       err;

  int         n_checks = 0;
  int         n_fail   = 0;

  ph_t        cur;   // phase the model expects
  logic [2:0] mq;    // mode the model expects to be latched

  calc_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .CLK       (CLK),
    .clear     (clear),
    .next      (next),
    .MS        (MS),
    .alu_done  (alu_done),
    .CS_out    (CS_out),
    .WE        (WE),
    .W1        (W1),
    .RES_WE    (RES_WE),
    .MS_out    (MS_out),
    .alu_start (alu_start),
    .Done_out  (Done_out),
    .err       (err)
  );

  always #5 CLK = ~CLK;

  // Observed word: {CS_out, WE, W1, RES_WE, MS_out, alu_start, Done_out, err}
  logic [11:0] obs;
  assign obs = {CS_out, WE, W1, RES_WE, MS_out, alu_start, Done_out, err};

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s @%0t: got %b expected %b (CS,WE,W1,RES_WE,MS,start,done,err)",
               tag, $time, got, want);
    end
  endtask

  function automatic logic [11:0] exp_vec(input ph_t p, input logic [2:0] m, input logic rw);
    logic valid;
    valid = (m >= 3'd1) && (m <= 3'd4);
    return {3'(p),
            (p == P_LOAD1) || (p == P_LOAD2),
            p inside {P_IDLE2, P_LOAD2, P_ISSUE, P_WAIT, P_DONE},
            rw,
            (p inside {P_ISSUE, P_WAIT, P_DONE}) ? m : 3'b000,
            (p == P_ISSUE) && valid,
            p == P_DONE,
            p == P_ERR};
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are sampled
  // one more unit later, well clear of the next edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample(input string tag, input logic rw);
    #1;
    check(tag, obs, exp_vec(cur, mq, rw));
  endtask

  // One-sample button press: the phase must hold for two edges, then move.
  task automatic press(input ph_t to);
    tick();
    next = 1'b1;
    sample("press_hold0", 1'b0);
    tick();
    next = 1'b0;
    sample("press_hold1", 1'b0);
    tick();
    sample("press_hold2", 1'b0);
    tick();
    cur = to;
  endtask

  task automatic do_reset();
    clear = 1'b1; next = 1'b0; alu_done = 1'b0; MS = 3'b000;
    tick();
    tick();
    clear = 1'b0;
    cur = P_IDLE1;
    mq  = 3'b000;
    sample("reset", 1'b0);
  endtask

  task automatic apply_clear();
    tick();
    clear = 1'b1;
    sample("pre_clear", 1'b0);
    tick();
    clear = 1'b0;
    cur = P_IDLE1;
    sample("after_clear", 1'b0);
  endtask

  // IDLE1 -> LOAD1 -> IDLE2 -> LOAD2, optionally with a stray alu_done in IDLE2.
  task automatic to_load2(input logic [2:0] m, input bit stray_done);
    press(P_LOAD1);
    sample("load1", 1'b0);
    tick();
    cur = P_IDLE2;
    sample("idle2", 1'b0);
    if (stray_done) begin
      tick();
      alu_done = 1'b1;
      sample("idle2_stray_done", 1'b0);
      tick();
      alu_done = 1'b0;
      sample("idle2_after_stray", 1'b0);
    end
    MS = m;
    press(P_LOAD2);
  endtask

  // Entered in the LOAD2 cycle with MS already driven. lat = WAIT cycle in
  // which alu_done arrives (0 = never); inject = next press in WAIT cycle 1;
  // clr_at = WAIT cycle in which clear is asserted (0 = never).
  task automatic run_op(input int lat, input bit inject, input int clr_at);
    sample("load2", 1'b0);
    mq = MS;
    tick();
    MS  = 3'($urandom);
    cur = P_ISSUE;
    sample("issue", 1'b0);
    tick();
    if (!((mq >= 3'd1) && (mq <= 3'd4))) begin
      cur = P_ERR;
      sample("err_bad_mode", 1'b0);
      return;
    end
    cur = P_WAIT;
    for (int j = 1; j <= TIMEOUT; j++) begin
      next = inject && (j == 1);
      if (j == clr_at) begin
        clear    = 1'b1;
        alu_done = 1'b0;
        sample("wait_clear", 1'b0);
        tick();
        clear    = 1'b0;
        next     = 1'b0;
        cur      = P_IDLE1;
        alu_done = 1'b1;
        sample("clear_then_done", 1'b0);
        tick();
        alu_done = 1'b0;
        sample("clear_idle", 1'b0);
        return;
      end
      alu_done = (j == lat);
      sample("wait", j == lat);
      MS = 3'($urandom);
      tick();
      alu_done = 1'b0;
      next     = 1'b0;
      if (j == lat) begin
        cur = P_DONE;
        sample("done", 1'b0);
        return;
      end
    end
    cur = P_ERR;
    sample("timeout_err", 1'b0);
  endtask

  task automatic leave_err();
    press(P_IDLE1);
    sample("err_to_idle1", 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    bit inj;
    int clr_at;
    int chains;

    do_reset();

    // Basic add, alu_done 3 cycles after alu_start.
    to_load2(3'b001, 1'b1);
    run_op(3, 1'b0, 0);

    // Chain a multiply on the result.
    MS = 3'b011;
    press(P_LOAD2);
    run_op(2, 1'b0, 0);

    // Invalid mode, then back to IDLE1.
    MS = 3'b111;
    press(P_LOAD2);
    run_op(1, 1'b0, 0);
    leave_err();

    // Timeout with no alu_done, with a dropped next press in WAIT.
    to_load2(3'b010, 1'b0);
    run_op(0, 1'b1, 0);
    leave_err();

    // alu_done in the last allowed WAIT cycle still wins.
    to_load2(3'b100, 1'b0);
    run_op(TIMEOUT, 1'b0, 0);

    // Dropped next press in WAIT with a later alu_done; then clear in DONE.
    MS = 3'b001;
    press(P_LOAD2);
    run_op(5, 1'b1, 0);
    apply_clear();

    // clear in WAIT cycle 2; a following alu_done is ignored.
    to_load2(3'b011, 1'b0);
    run_op(0, 1'b0, 2);

    // Randomized passes.
    for (int it = 0; it < 25; it++) begin
      lat    = $urandom_range(0, TIMEOUT);
      inj    = ((lat == 0) || (lat >= 3)) && ($urandom_range(0, 1) == 1);
      clr_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, TIMEOUT) : 0;
      to_load2(3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0);
      run_op(lat, inj, clr_at);
      chains = $urandom_range(0, 2);
      while (cur == P_DONE && chains > 0) begin
        chains--;
        lat = $urandom_range(0, TIMEOUT);
        inj = ((lat == 0) || (lat >= 3)) && ($urandom_range(0, 1) == 1);
        MS  = 3'($urandom_range(0, 7));
        press(P_LOAD2);
        run_op(lat, inj, 0);
      end
      if (cur == P_DONE) apply_clear();
      else if (cur == P_ERR) leave_err();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
